// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between several
// writeback requesters, with a registered write stage and read/write hazard flags
// for the decode stage (the register file has no write-to-read bypass).
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int WIDTH_DATA = 32
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          stall_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [5*NUM_REQ-1:0]          req_addr_i,
    input  logic [WIDTH_DATA*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          reg_write_o,
    output logic [4:0]                    wr_register_o,
    output logic [WIDTH_DATA-1:0]         wr_data_o,
    input  logic [4:0]                    rd_register_1_i,
    input  logic [4:0]                    rd_register_2_i,
    output logic                          hazard_1_o,
    output logic                          hazard_2_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Requester tables are padded to a power of two so any index value is legal.
    localparam int SLOTS = 1 << IDX_W;

    logic [SLOTS-1:0]      valid_arr;
    logic [4:0]            addr_arr [SLOTS];
    logic [WIDTH_DATA-1:0] data_arr [SLOTS];

    logic [IDX_W-1:0]      last_reg;
    logic [IDX_W-1:0]      last_next;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      cand_idx;
    logic                  grant_found;

    logic                  reg_write_reg;
    logic                  reg_write_next;
    logic [4:0]            wr_register_reg;
    logic [4:0]            wr_register_next;
    logic [WIDTH_DATA-1:0] wr_data_reg;
    logic [WIDTH_DATA-1:0] wr_data_next;

    // Unpack the flat request buses into per-requester tables; padding slots are never valid.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < NUM_REQ) begin : g_real
                assign valid_arr[gi] = req_valid_i[gi];
                assign addr_arr[gi]  = req_addr_i[5*gi +: 5];
                assign data_arr[gi]  = req_data_i[WIDTH_DATA*gi +: WIDTH_DATA];
            end else begin : g_pad
                assign valid_arr[gi] = 1'b0;
                assign addr_arr[gi]  = 5'd0;
                assign data_arr[gi]  = '0;
            end
        end
    endgenerate

    // Search last+1, last+2, ... (mod NUM_REQ) for the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_reg;
        cand_idx    = last_reg;
        if (!reset_i && !stall_i) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand_idx = IDX_W'((int'(last_reg) + k) % NUM_REQ);
                if (!grant_found && valid_arr[cand_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand_idx;
                end
            end
        end
    end

    // One-hot ready; a grant only goes to a valid requester, so ready implies handshake.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready_o[gi] = grant_found && (grant_idx == IDX_W'(gi));
        end
    endgenerate

    // Next-state for the pointer and the write stage; x0 writes are consumed but dropped.
    always_comb begin
        last_next        = last_reg;
        reg_write_next   = 1'b0;
        wr_register_next = wr_register_reg;
        wr_data_next     = wr_data_reg;
        if (grant_found) begin
            last_next = grant_idx;
            if (addr_arr[grant_idx] != 5'd0) begin
                reg_write_next   = 1'b1;
                wr_register_next = addr_arr[grant_idx];
                wr_data_next     = data_arr[grant_idx];
            end
        end
    end

    // State register; reset discards any in-flight write and points at the last requester.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            last_reg        <= IDX_W'(NUM_REQ - 1);
            reg_write_reg   <= 1'b0;
            wr_register_reg <= 5'd0;
            wr_data_reg     <= '0;
        end else begin
            last_reg        <= last_next;
            reg_write_reg   <= reg_write_next;
            wr_register_reg <= wr_register_next;
            wr_data_reg     <= wr_data_next;
        end
    end

    assign reg_write_o   = reg_write_reg;
    assign wr_register_o = wr_register_reg;
    assign wr_data_o     = wr_data_reg;

    // A decode read of the register being written this cycle would see stale data.
    assign hazard_1_o = reg_write_reg && (rd_register_1_i == wr_register_reg) && (rd_register_1_i != 5'd0);
    assign hazard_2_o = reg_write_reg && (rd_register_2_i == wr_register_reg) && (rd_register_2_i != 5'd0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes are queued when a
// handshake is expected and checked against the write stage one cycle later.
module tb_regfile_write_arbiter;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        stall_i = 1'b0;
    logic [2:0]  req_valid_i = '0;
    logic [14:0] req_addr_i = '0;
    logic [95:0] req_data_i = '0;
    logic [2:0]  req_ready_o;
    logic        reg_write_o;
    logic [4:0]  wr_register_o;
    logic [31:0] wr_data_o;
    logic [4:0]  rd_register_1_i = '0;
    logic [4:0]  rd_register_2_i = '0;
    logic        hazard_1_o;
    logic        hazard_2_o;

    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [4:0]  held_a = '0;
    logic [31:0] held_d = '0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] rf [32];

    regfile_write_arbiter #(.NUM_REQ(3), .WIDTH_DATA(32)) dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .stall_i         (stall_i),
        .req_valid_i     (req_valid_i),
        .req_addr_i      (req_addr_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .reg_write_o     (reg_write_o),
        .wr_register_o   (wr_register_o),
        .wr_data_o       (wr_data_o),
        .rd_register_1_i (rd_register_1_i),
        .rd_register_2_i (rd_register_2_i),
        .hazard_1_o      (hazard_1_o),
        .hazard_2_o      (hazard_2_o)
    );

    always #5 clock_i = ~clock_i;

    // Register file model fed by the write port.
    always @(posedge clock_i) begin
        if (reg_write_o) rf[wr_register_o] <= wr_data_o;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [4:0] a, input logic [31:0] d);
        req_addr_i[5*k +: 5]  = a;
        req_data_i[32*k +: 32] = d;
    endtask

    task automatic check_out(input string tag);
        wr_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s/queue: observed empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "/reg_write"}, {31'd0, reg_write_o}, {31'd0, e.we});
            chk({tag, "/wr_register"}, {27'd0, wr_register_o}, {27'd0, e.a});
            chk({tag, "/wr_data"}, wr_data_o, e.d);
        end
    endtask

    // One arbitration cycle: check ready and the previous cycle's write, queue the expected write.
    task automatic do_cycle(input logic [2:0] exp_ready, input string tag);
        logic [4:0]  a;
        logic [31:0] d;
        #1;
        chk({tag, "/ready"}, {29'd0, req_ready_o}, {29'd0, exp_ready});
        $display("[TB] %s valid=%b stall=%b ready=%b we=%b reg=%0d data=%h",
                 tag, req_valid_i, stall_i, req_ready_o, reg_write_o, wr_register_o, wr_data_o);
        check_out(tag);
        a = held_a;
        d = held_d;
        for (int k = 0; k < 3; k++) begin
            if (exp_ready[k]) begin
                a = req_addr_i[5*k +: 5];
                d = req_data_i[32*k +: 32];
            end
        end
        if (exp_ready != 3'b000 && a != 5'd0) begin
            held_a = a;
            held_d = d;
            exp_q.push_back('{we: 1'b1, a: a, d: d});
        end else begin
            exp_q.push_back('{we: 1'b0, a: held_a, d: held_d});
        end
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        set_req(0, 5'd5, 32'hA000_0000);
        set_req(1, 5'd6, 32'hA000_0001);
        set_req(2, 5'd7, 32'hA000_0002);
        req_valid_i = 3'b111;
        #1 reset_i = 1'b1;
        #1;
        chk("reset/ready", {29'd0, req_ready_o}, 32'd0);
        chk("reset/reg_write", {31'd0, reg_write_o}, 32'd0);
        chk("reset/wr_register", {27'd0, wr_register_o}, 32'd0);
        chk("reset/wr_data", wr_data_o, 32'd0);
        @(posedge clock_i);
        #1;
        chk("reset_held/ready", {29'd0, req_ready_o}, 32'd0);
        reset_i = 1'b0;
        exp_q.push_back('{we: 1'b0, a: 5'd0, d: 32'd0});

        // Round-robin with all three requesters valid.
        for (int i = 0; i < 6; i++) begin
            do_cycle(3'b001 << (i % 3), $sformatf("rr%0d", i));
        end

        // Asynchronous reset mid-cycle while a write is in flight.
        req_valid_i = 3'b000;
        #1;
        check_out("rr_last");
        reset_i = 1'b1;
        #1;
        chk("midreset/reg_write", {31'd0, reg_write_o}, 32'd0);
        chk("midreset/wr_register", {27'd0, wr_register_o}, 32'd0);
        chk("midreset/wr_data", wr_data_o, 32'd0);
        exp_q.delete();
        held_a = '0;
        held_d = '0;
        exp_q.push_back('{we: 1'b0, a: 5'd0, d: 32'd0});
        req_valid_i = 3'b111;
        #1;
        chk("midreset/ready", {29'd0, req_ready_o}, 32'd0);
        @(posedge clock_i);
        #1;
        chk("midreset_edge/reg_write", {31'd0, reg_write_o}, 32'd0);
        reset_i = 1'b0;
        do_cycle(3'b001, "post_reset");

        // x0 write from requester 1 is consumed but never written; pointer moves to 1.
        set_req(1, 5'd0, 32'hDEAD_BEEF);
        req_valid_i = 3'b010;
        do_cycle(3'b010, "x0_drop");
        set_req(1, 5'd6, 32'hA000_0001);
        req_valid_i = 3'b111;
        do_cycle(3'b100, "x0_last");
        req_valid_i = 3'b000;
        do_cycle(3'b000, "x0_idle");

        // Stall holds off the grant for three cycles.
        req_valid_i = 3'b010;
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) do_cycle(3'b000, $sformatf("stall%0d", i));
        stall_i = 1'b0;
        do_cycle(3'b010, "unstall");
        req_valid_i = 3'b000;
        do_cycle(3'b000, "unstall_wr");

        // Hazard against the in-flight write, then read back through the register file.
        set_req(0, 5'd9, 32'h0000_1234);
        req_valid_i = 3'b001;
        do_cycle(3'b001, "hz_grant");
        req_valid_i = 3'b000;
        rd_register_1_i = 5'd9;
        rd_register_2_i = 5'd0;
        #1;
        chk("hz/hazard_1", {31'd0, hazard_1_o}, 32'd1);
        chk("hz/hazard_2", {31'd0, hazard_2_o}, 32'd0);
        rd_register_1_i = 5'd10;
        rd_register_2_i = 5'd9;
        #1;
        chk("hz_swap/hazard_1", {31'd0, hazard_1_o}, 32'd0);
        chk("hz_swap/hazard_2", {31'd0, hazard_2_o}, 32'd1);
        rd_register_1_i = 5'd9;
        rd_register_2_i = 5'd0;
        do_cycle(3'b000, "hz_write");
        chk("hz/rf_x9", rf[9], 32'h0000_1234);
        chk("hz_after/hazard_1", {31'd0, hazard_1_o}, 32'd0);

        // Fairness: requester 0 holds valid, requester 2 pulses and is served promptly.
        set_req(0, 5'd5, 32'hA000_0000);
        req_valid_i = 3'b001;
        do_cycle(3'b001, "fair0");
        req_valid_i = 3'b101;
        do_cycle(3'b100, "fair2");
        req_valid_i = 3'b001;
        do_cycle(3'b001, "fair0b");
        req_valid_i = 3'b000;
        do_cycle(3'b000, "fair_idle");
        #1;
        check_out("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
